// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// lane masks and the rule that decides whether an access spans two RAM words.
package lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;
  localparam logic [1:0] LSU_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ERR  = 3'd1;
  localparam logic [2:0] ST_GNT1 = 3'd2;
  localparam logic [2:0] ST_RV1  = 3'd3;
  localparam logic [2:0] ST_GNT2 = 3'd4;
  localparam logic [2:0] ST_RV2  = 3'd5;

  function automatic logic [3:0] size_mask(input logic [1:0] typ);
    case (typ)
      LSU_BYTE: return 4'b0001;
      LSU_HALF: return 4'b0011;
      LSU_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic needs_split(input logic [1:0] typ, input logic [1:0] off);
    case (typ)
      LSU_HALF: return (off == 2'd3);
      LSU_WORD: return (off != 2'd0);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Load data alignment: shifts the one or two fetched words down by the byte offset,
// then extracts byte/half/word and sign- or zero-extends. Purely combinational.
module lsu_rdata_align
  import lsu_pkg::*;
(
  input  logic [31:0] r1_i,
  input  logic [31:0] r2_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic        sign_ext_i,
  output logic [31:0] res_o
);

  logic [31:0] w;

  assign w = 32'({r2_i, r1_i} >> {off_i, 3'b000});

  always_comb begin
    case (type_i)
      LSU_BYTE: res_o = {{24{sign_ext_i & w[7]}}, w[7:0]};
      LSU_HALF: res_o = {{16{sign_ext_i & w[15]}}, w[15:0]};
      default:  res_o = w;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: splits core accesses into one or two RAM word transactions over
// req/gnt/rvalid; done two cycles after accept (four when split); stalls indefinitely on gnt.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_type_i,
  input  logic              lsu_sign_ext_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              data_req_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d, sext_q, sext_d, split_q, split_d;
  logic              arm_q, arm_d, done_q, done_d, err_q, err_d;
  logic [1:0]        type_q, type_d, off_q, off_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, r1_q, r1_d, rdata_q, rdata_d;
  logic              p1_cmp, p2_cmp, in_gnt2;
  logic [DATA_W-1:0] al_r1, al_r2, al_res;
  logic [7:0]        be_wide;
  logic [5:0]        sh;
  logic              unused_addr;

  assign unused_addr = ^lsu_addr_i[31:ADDR_W+2];

  // arm_q is the one-cycle turnaround between the two halves of a split access
  assign in_gnt2 = (state_q == ST_GNT2) && !arm_q;

  always_comb begin
    p1_cmp = 1'b0;
    p2_cmp = 1'b0;
    case (state_q)
      ST_GNT1: p1_cmp = data_gnt_i & data_rvalid_i;
      ST_RV1:  p1_cmp = data_rvalid_i;
      ST_GNT2: p2_cmp = in_gnt2 & data_gnt_i & data_rvalid_i;
      ST_RV2:  p2_cmp = data_rvalid_i;
      default: ;
    endcase
  end

  assign al_r1 = p1_cmp ? data_rdata_i : r1_q;
  assign al_r2 = p2_cmp ? data_rdata_i : '0;

  lsu_rdata_align u_align (
    .r1_i       (al_r1),
    .r2_i       (al_r2),
    .off_i      (off_q),
    .type_i     (type_q),
    .sign_ext_i (sext_q),
    .res_o      (al_res)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    sext_d  = sext_q;
    off_d   = off_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    split_d = split_q;
    r1_d    = r1_q;
    rdata_d = rdata_q;
    arm_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i && !done_q) begin
          we_d    = lsu_we_i;
          type_d  = lsu_type_i;
          sext_d  = lsu_sign_ext_i;
          off_d   = lsu_addr_i[1:0];
          wa_d    = lsu_addr_i[ADDR_W+1:2];
          wdata_d = lsu_wdata_i;
          split_d = needs_split(lsu_type_i, lsu_addr_i[1:0]);
          if (lsu_type_i == LSU_ILL) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_GNT1;
          end
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      ST_GNT1: if (data_gnt_i && !data_rvalid_i) state_d = ST_RV1;
      ST_GNT2: if (in_gnt2 && data_gnt_i && !data_rvalid_i) state_d = ST_RV2;
      default: ;
    endcase
    if (p1_cmp) begin
      r1_d = data_rdata_i;
      if (split_q) begin
        state_d = ST_GNT2;
        arm_d   = 1'b1;
      end
    end
    if ((p1_cmp && !split_q) || p2_cmp) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      if (!we_q) rdata_d = al_res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      wa_q    <= '0;
      wdata_q <= '0;
      split_q <= 1'b0;
      r1_q    <= '0;
      rdata_q <= '0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      r1_q    <= r1_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Upper nibble of the shifted mask is exactly the second-word byte enables
  assign be_wide = {4'b0000, size_mask(type_q)} << off_q;
  assign sh      = {1'b0, off_q, 3'b000};

  assign data_req_o   = (state_q == ST_GNT1) || in_gnt2;
  assign data_we_o    = data_req_o & we_q;
  assign data_addr_o  = !data_req_o ? '0 : (in_gnt2 ? wa_q + ADDR_W'(1) : wa_q);
  assign data_be_o    = !data_req_o ? 4'b0000 : (in_gnt2 ? be_wide[7:4] : be_wide[3:0]);
  assign data_wdata_o = !data_req_o ? '0 : ((wdata_q << sh) | (wdata_q >> (6'd32 - sh)));

  assign lsu_busy_o  = (state_q != ST_IDLE) || done_q;
  assign lsu_done_o  = done_q;
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus randomized accesses against a
// byte-addressed memory model; a responder process plays the RAM side of the handshake.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_sign_ext_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic        lsu_busy_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic [4:0]  data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  always #5 clk_i = ~clk_i;

  lsu_mem_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
    .lsu_rdata_o(lsu_rdata_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] ram [32];
  logic [7:0]  ref_mem [128];

  int gnt_dly = 0, rv_dly = 0;
  bit rand_dly = 1'b0;
  logic [4:0]  log_addr [$];
  logic [3:0]  log_be [$];
  logic        log_we [$];
  logic [31:0] log_wd [$];
  int          log_gd [$];
  int          log_rd [$];
  int req_cycles = 0, done_cnt = 0, err_nodone = 0, unstable = 0;

  always @(negedge clk_i) begin
    if (lsu_done_o) done_cnt++;
    if (data_req_o) req_cycles++;
    if (lsu_err_o && !lsu_done_o) err_nodone++;
  end

  // RAM responder: grants after a delay, returns rvalid a further delay later
  initial begin : responder
    int gcnt, rcnt, gd, rd;
    bit outst;
    logic [31:0] pend;
    logic [4:0] a0;
    logic [3:0] b0;
    logic w0;
    gcnt = -1; rcnt = 0; gd = 0; rd = 0; outst = 1'b0; pend = '0; a0 = '0; b0 = '0; w0 = 1'b0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (!rst_ni) begin
        gcnt = -1;
        outst = 1'b0;
      end else if (outst) begin
        if (rcnt == 0) begin
          data_rvalid_i = 1'b1;
          data_rdata_i = pend;
          outst = 1'b0;
        end else rcnt--;
      end else if (data_req_o) begin
        if (gcnt < 0) begin
          gd = rand_dly ? int'($urandom_range(0, 3)) : gnt_dly;
          rd = rand_dly ? int'($urandom_range(0, 3)) : rv_dly;
          gcnt = gd; a0 = data_addr_o; b0 = data_be_o; w0 = data_we_o;
        end else if (data_addr_o !== a0 || data_be_o !== b0 || data_we_o !== w0) unstable++;
        if (gcnt == 0) begin
          data_gnt_i = 1'b1;
          log_addr.push_back(data_addr_o); log_be.push_back(data_be_o);
          log_we.push_back(data_we_o); log_wd.push_back(data_wdata_o);
          log_gd.push_back(gd); log_rd.push_back(rd);
          pend = ram[data_addr_o];
          if (data_we_o)
            for (int i = 0; i < 4; i++)
              if (data_be_o[i]) ram[data_addr_o][8*i +: 8] = data_wdata_o[8*i +: 8];
          if (rd == 0) begin
            data_rvalid_i = 1'b1;
            data_rdata_i = pend;
          end else begin
            outst = 1'b1;
            rcnt = rd - 1;
          end
          gcnt = -1;
        end else gcnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_be.delete(); log_we.delete();
    log_wd.delete(); log_gd.delete(); log_rd.delete();
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ram[idx] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*idx + i] = v[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] t);
    return (t == LSU_BYTE) ? 1 : (t == LSU_HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] t, input logic sx, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = nbytes(t);
    for (int j = 0; j < n; j++) v[8*j +: 8] = ref_mem[(int'(a[6:0]) + j) % 128];
    if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd);
    for (int j = 0; j < nbytes(t); j++) ref_mem[(int'(a[6:0]) + j) % 128] = wd[8*j +: 8];
  endtask

  // Drives one access and returns cycles from accept to done (200 = no done seen)
  task automatic do_access(input logic we, input logic [1:0] t, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er);
    tick();
    lsu_we_i = we; lsu_type_i = t; lsu_sign_ext_i = sx; lsu_addr_i = a; lsu_wdata_i = wd;
    lsu_req_i = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!lsu_done_o && lat < 200);
    rd = lsu_rdata_o;
    er = lsu_err_o;
    lsu_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    n_cmp++;
    if ({lsu_busy_o, lsu_done_o, lsu_err_o, data_req_o, data_we_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {lsu_busy_o, lsu_done_o, lsu_err_o, data_req_o, data_we_o});
    end
    n_cmp++;
    if (lsu_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 00000000", lsu_rdata_o);
    end
    n_cmp++;
    if ({data_addr_o, data_be_o, data_wdata_o} !== 41'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h/%b/%h want 0", data_addr_o, data_be_o, data_wdata_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er;
    gnt_dly = 0; rv_dly = 0; clear_log();
    do_access(1'b1, LSU_WORD, 1'b0, 32'h08, 32'hDEADBEEF, lat, rd, er);
    ref_store(LSU_WORD, 32'h08, 32'hDEADBEEF);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0) begin
      n_bad++; $display("FAIL wstore_timing: got lat %0d err %b want lat 2 err 0", lat, er);
    end
    n_cmp++;
    if (log_addr.size() != 1 || log_addr[0] !== 5'd2 || log_be[0] !== 4'b1111 ||
        log_we[0] !== 1'b1 || log_wd[0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wstore_bus: got %0d reqs first %h/%b/%h want 1 req 02/1111/deadbeef",
                        log_addr.size(), log_addr[0], log_be[0], log_wd[0]);
    end
  endtask

  task automatic test_byte_load();
    int lat; logic [31:0] rd; logic er;
    gnt_dly = 0; rv_dly = 0; clear_log();
    set_word(1, 32'h80112233);
    do_access(1'b0, LSU_BYTE, 1'b1, 32'h07, 32'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hFFFFFF80 || rd !== ref_load(LSU_BYTE, 1'b1, 32'h07) || lat !== 2) begin
      n_bad++; $display("FAIL bload_sext: got %h lat %0d want ffffff80 lat 2", rd, lat);
    end
    n_cmp++;
    if (log_addr.size() != 1 || log_addr[0] !== 5'd1 || log_be[0] !== 4'b1000 || log_we[0] !== 1'b0) begin
      n_bad++; $display("FAIL bload_bus: got %0d reqs %h/%b want 1 req 01/1000", log_addr.size(), log_addr[0], log_be[0]);
    end
    do_access(1'b0, LSU_BYTE, 1'b0, 32'h07, 32'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h00000080) begin
      n_bad++; $display("FAIL bload_zext: got %h want 00000080", rd);
    end
  endtask

  task automatic test_misaligned_load();
    int lat; logic [31:0] rd; logic er;
    gnt_dly = 0; rv_dly = 0; clear_log();
    set_word(1, 32'hAABBCCDD);
    set_word(2, 32'h11223344);
    do_access(1'b0, LSU_WORD, 1'b0, 32'h06, 32'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h3344AABB || lat !== 4) begin
      n_bad++; $display("FAIL misal_load: got %h lat %0d want 3344aabb lat 4", rd, lat);
    end
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[0] !== 5'd1 || log_be[0] !== 4'b1100 ||
        log_addr[1] !== 5'd2 || log_be[1] !== 4'b0011) begin
      n_bad++; $display("FAIL misal_bus: got %0d reqs want 01/1100 then 02/0011", log_addr.size());
    end
  endtask

  task automatic test_wrap_store();
    int lat; logic [31:0] rd; logic er;
    gnt_dly = 0; rv_dly = 0; clear_log();
    do_access(1'b1, LSU_HALF, 1'b0, 32'h7F, 32'h00001234, lat, rd, er);
    ref_store(LSU_HALF, 32'h7F, 32'h00001234);
    n_cmp++;
    if (log_addr.size() != 2 || log_addr[0] !== 5'd31 || log_be[0] !== 4'b1000 || log_wd[0][31:24] !== 8'h34 ||
        log_addr[1] !== 5'd0 || log_be[1] !== 4'b0001 || log_wd[1][7:0] !== 8'h12 || lat !== 4) begin
      n_bad++; $display("FAIL wrap_store: got %0d reqs lat %0d want 31/1000/34 then 0/0001/12 lat 4", log_addr.size(), lat);
    end
  endtask

  task automatic test_stall();
    int lat, d0, r0; logic [31:0] rd; logic er;
    gnt_dly = 3; rv_dly = 2; clear_log();
    unstable = 0; d0 = done_cnt; r0 = req_cycles;
    do_access(1'b0, LSU_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er);
    n_cmp++;
    if (lat !== 7 || rd !== ref_load(LSU_WORD, 1'b0, 32'h10)) begin
      n_bad++; $display("FAIL stall_result: got %h lat %0d want %h lat 7", rd, lat, ref_load(LSU_WORD, 1'b0, 32'h10));
    end
    n_cmp++;
    if (unstable !== 0 || req_cycles - r0 !== 4) begin
      n_bad++; $display("FAIL stall_req: got unstable %0d req cycles %0d want 0 and 4", unstable, req_cycles - r0);
    end
    tick();
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++; $display("FAIL stall_done: got %0d done pulses want 1", done_cnt - d0);
    end
    gnt_dly = 0; rv_dly = 0;
  endtask

  task automatic test_illegal();
    int lat, r0; logic [31:0] rd; logic er;
    clear_log(); r0 = req_cycles;
    do_access(1'b0, LSU_ILL, 1'b0, 32'h20, 32'h0, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || er !== 1'b1) begin
      n_bad++; $display("FAIL illegal_err: got lat %0d err %b want lat 1 err 1", lat, er);
    end
    tick();
    n_cmp++;
    if (req_cycles - r0 !== 0 || log_addr.size() != 0 || err_nodone !== 0 || lsu_err_o !== 1'b0) begin
      n_bad++; $display("FAIL illegal_noreq: got req cycles %0d stray err %0d want 0 and 0", req_cycles - r0, err_nodone);
    end
  endtask

  task automatic test_reset_mid();
    int lat, d0; logic [31:0] rd; logic er;
    gnt_dly = 0; rv_dly = 6;
    tick();
    lsu_we_i = 1'b0; lsu_type_i = LSU_WORD; lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0C; lsu_req_i = 1'b1;
    tick();
    tick();
    d0 = done_cnt;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({lsu_busy_o, lsu_done_o, lsu_err_o, data_req_o} !== 4'b0 || lsu_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_out: got %b rdata %h want 0000 and 0", {lsu_busy_o, lsu_done_o, lsu_err_o, data_req_o}, lsu_rdata_o);
    end
    lsu_req_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if (done_cnt !== d0) begin
      n_bad++; $display("FAIL rstmid_nodone: got %0d done pulses want 0", done_cnt - d0);
    end
    rv_dly = 0;
    do_access(1'b0, LSU_HALF, 1'b1, 32'h0E, 32'h0, lat, rd, er);
    n_cmp++;
    if (rd !== ref_load(LSU_HALF, 1'b1, 32'h0E) || lat !== 2) begin
      n_bad++; $display("FAIL rstmid_after: got %h lat %0d want %h lat 2", rd, lat, ref_load(LSU_HALF, 1'b1, 32'h0E));
    end
  endtask

  task automatic test_random();
    int lat, n, base, nreq, exp_lat, widx, lane;
    logic [31:0] rd, a, wd, exp;
    logic er, we, sx, ok, split;
    logic [1:0] t;
    logic [4:0] wa;
    logic [3:0] ebe [2];
    logic [31:0] ewd [2];
    rand_dly = 1'b1;
    for (int k = 0; k < 60; k++) begin
      t = ($urandom_range(0, 7) == 0) ? LSU_ILL : 2'($urandom_range(0, 2));
      a = $urandom; wd = $urandom; we = 1'($urandom); sx = 1'($urandom);
      exp = ref_load(t, sx, a);
      base = log_addr.size();
      do_access(we, t, sx, a, wd, lat, rd, er);
      nreq = log_addr.size() - base;
      if (t == LSU_ILL) begin
        n_cmp++;
        if (er !== 1'b1 || lat !== 1 || nreq != 0) begin
          n_bad++; $display("FAIL rand_ill[%0d]: got err %b lat %0d reqs %0d want 1/1/0", k, er, lat, nreq);
        end
        continue;
      end
      n = nbytes(t);
      split = (int'(a[1:0]) + n) > 4;
      wa = a[6:2];
      ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
      for (int j = 0; j < n; j++) begin
        widx = ((int'(a[6:0]) + j) % 128) / 4;
        lane = (int'(a[1:0]) + j) % 4;
        ebe[(widx == int'(wa)) ? 0 : 1][lane] = 1'b1;
        ewd[(widx == int'(wa)) ? 0 : 1][8*lane +: 8] = wd[8*j +: 8];
      end
      n_cmp++;
      if (er !== 1'b0 || nreq != (split ? 2 : 1)) begin
        n_bad++; $display("FAIL rand_reqs[%0d]: got err %b reqs %0d want 0 and %0d", k, er, nreq, split ? 2 : 1);
        continue;
      end
      ok = 1'b1;
      for (int p = 0; p < nreq; p++) begin
        if (log_addr[base+p] !== wa + 5'(p) || log_be[base+p] !== ebe[p] || log_we[base+p] !== we) ok = 1'b0;
        for (int i = 0; i < 4; i++)
          if (we && ebe[p][i] && log_wd[base+p][8*i +: 8] !== ewd[p][8*i +: 8]) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL rand_bus[%0d]: addr %h type %0d first req %h/%b want %h/%b", k, a, t, log_addr[base], log_be[base], wa, ebe[0]);
      end
      exp_lat = 1 + log_gd[base] + 1 + log_rd[base];
      if (split) exp_lat += 1 + log_gd[base+1] + 1 + log_rd[base+1];
      n_cmp++;
      if (lat !== exp_lat) begin
        n_bad++; $display("FAIL rand_lat[%0d]: got %0d want %0d", k, lat, exp_lat);
      end
      if (we) ref_store(t, a, wd);
      else begin
        n_cmp++;
        if (rd !== exp) begin
          n_bad++; $display("FAIL rand_load[%0d]: addr %h type %0d got %h want %h", k, a, t, rd, exp);
        end
      end
    end
    rand_dly = 1'b0;
  endtask

  task automatic test_memory();
    logic [31:0] e;
    for (int w = 0; w < 32; w++) begin
      e = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      n_cmp++;
      if (ram[w] !== e) begin
        n_bad++; $display("FAIL mem_word[%0d]: got %h want %h", w, ram[w], e);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 32; w++) set_word(w, $urandom);
    test_reset();
    test_word_store();
    test_byte_load();
    test_misaligned_load();
    test_wrap_store();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    test_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting between the core's execute stage and the data RAM.
- Takes one byte, halfword or word access per request and generates word address, byte-write enables and lane-aligned write data.
- Runs the data_req/data_gnt/data_rvalid handshake. A misaligned access is split into two word transactions.
- Returns load data aligned to bit 0, sign- or zero-extended.

Parameters:
- ADDR_W, 5, RAM word-address width (matches a 32-entry data RAM).
- DATA_W, 32, data width. Fixed 4 byte lanes; other values unsupported.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- lsu_req_i  in  1  core access request; sampled only when lsu_busy_o=0.
- lsu_we_i  in  1  1=store, 0=load.
- lsu_type_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- lsu_sign_ext_i  in  1  1=sign-extend load result.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_busy_o  out  1  high from the cycle after acceptance until the done cycle inclusive.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_err_o  out  1  one-cycle pulse coincident with done, for illegal type.
- lsu_rdata_o  out  32  load result; valid when lsu_done_o=1 for a load; held until next done.
- data_req_o  out  1  RAM request.
- data_addr_o  out  ADDR_W  RAM word address.
- data_we_o  out  1  write request.
- data_be_o  out  4  byte-write enables.
- data_wdata_o  out  32  lane-aligned write data.
- data_gnt_i  in  1  RAM grant.
- data_rvalid_i  in  1  RAM response valid (loads and stores).
- data_rdata_i  in  32  RAM read data.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; every output 0; lsu_rdata_o=0; all captured registers cleared. Reset mid-transaction abandons it and issues no done.
- Accept: in IDLE with lsu_req_i=1, capture we, type, sign_ext, addr, wdata. Let off=addr[1:0] and wa=addr[ADDR_W+1:2].
- Illegal type (11): go to ERR. The next cycle pulses lsu_done_o and lsu_err_o, issues no RAM request, then returns to IDLE.
- Split rule: access is split when off+size_bytes>4 (half at off=3; word at off≠0). Bytes never split.
- Part 1 controls: addr=wa; be=(size mask)<<off, truncated to 4 bits.
- Part 2 controls: addr=(wa+1) mod 2^ADDR_W (wraps at top); be=(size mask)>>(4-off).
- Store data: data_wdata_o = rotate-left(wdata, 8*off) for both parts.
- FSM states: IDLE, ERR, GNT1, RV1, GNT2, RV2.
- GNT1 / GNT2:
  - data_req_o=1 with the part's addr, we and be held stable until data_gnt_i=1.
  - On grant with data_rvalid_i=1 in the same cycle, treat as complete for that part. Otherwise go to RV1/RV2 with data_req_o=0.
- RV1 / RV2: wait for data_rvalid_i. rvalid without an outstanding request is ignored.
- Part 1 complete: capture rdata into r1. If split, go to GNT2; else finish.
- Part 2 complete: capture rdata into r2 and finish.
- Finish:
  - The next cycle pulses lsu_done_o and updates lsu_rdata_o; state returns to IDLE.
  - Load assembly: w = low 32 bits of ({r2,r1} >> 8*off), with r2=0 if not split. Extract byte/half/word and sign/zero-extend per lsu_sign_ext_i.
  - Stores leave lsu_rdata_o unchanged.
- Latency: unsplit load/store with gnt and rvalid in their first cycle gives accept T, req T+1, done T+2. Split adds 2 cycles.
- lsu_req_i while busy is ignored; the core holds its request until done.
- No timeout: a stalled grant holds the FSM indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - size encoding constants (LSU_BYTE/HALF/WORD/ILL);
  - FSM state enum;
  - function size_mask(type) returning 0001/0011/1111;
  - function needs_split(type,off).
- One natural sub-module: lsu_rdata_align. Combinational: r1, r2, off, type, sign_ext → 32-bit result. Unit-testable alone.
- Top holds the FSM, captured registers and address/be/wdata generation.

Test Plan:
- Word store addr 0x08, wdata 0xDEADBEEF, immediate gnt+rvalid -> one req: addr 2, be 1111, wdata 0xDEADBEEF; done at T+2; no err.
- Byte load addr 0x07, sign_ext=1, RAM word1=0x80112233 -> addr 1, be 1000; lsu_rdata_o=0xFFFFFF80. Same with sign_ext=0 -> 0x00000080.
- Misaligned word load addr 0x06, word1=0xAABBCCDD, word2=0x11223344 -> two reqs (addr 1 be 1100, addr 2 be 0011); result 0x3344AABB; done T+4.
- Half store addr 0x7F (ADDR_W=5, last word) wdata 0x1234 -> req addr 31 be 1000 wdata lane3=0x34; then addr 0 (wrap) be 0001 lane0=0x12.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> req/addr/be stable across stall; req drops after gnt; exactly one done. Illegal type 11 -> done+err next cycle, data_req_o never asserted.
- rst_ni dropped while in RV1 -> outputs 0 immediately; no done; next accepted request completes normally.
